// File: rtl/hazard_if.sv
// hazard_if: pipeline-to-hazard-controller signal bundle.
interface hazard_if;
  logic [4:0]  Rs1_D, Rs2_D, Rd_E;
  logic        Mem_Read_E, PC_Src_E, Dmem_Req_M, Dmem_Ready_M;
  logic        Stall_F, Stall_En, Flush_D, Flush_E, Freeze_EM, Mem_Timeout;
  logic [15:0] Stall_Cycles, Flush_Count;
  modport master (
    output Rs1_D, Rs2_D, Rd_E, Mem_Read_E, PC_Src_E, Dmem_Req_M, Dmem_Ready_M,
    input  Stall_F, Stall_En, Flush_D, Flush_E, Freeze_EM, Mem_Timeout, Stall_Cycles, Flush_Count
  );
  modport slave (
    input  Rs1_D, Rs2_D, Rd_E, Mem_Read_E, PC_Src_E, Dmem_Req_M, Dmem_Ready_M,
    output Stall_F, Stall_En, Flush_D, Flush_E, Freeze_EM, Mem_Timeout, Stall_Cycles, Flush_Count
  );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/flush/freeze control with memory-wait timeout and stat counters.
module hazard_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic     CLK,
  input  logic     RST,
  hazard_if.slave  hz
);
  typedef enum logic {S_RUN, S_WAIT} state_t;
  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);
  state_t      state_q;
  logic [7:0]  wait_cnt_q;
  logic        timeout_q;
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        mem_wait, load_use, stall_en, flush_d;
  assign mem_wait = hz.Dmem_Req_M & ~hz.Dmem_Ready_M;
  assign load_use = hz.Mem_Read_E & (hz.Rd_E != 5'd0) & (hz.Rd_E == hz.Rs1_D | hz.Rd_E == hz.Rs2_D);
  // Priority: reset, memory wait, taken branch, load-use.
  assign stall_en     = ~RST & (mem_wait | (~hz.PC_Src_E & load_use));
  assign flush_d      = ~RST & ~mem_wait & hz.PC_Src_E;
  assign hz.Stall_F   = stall_en;
  assign hz.Stall_En  = stall_en;
  assign hz.Flush_D   = flush_d;
  assign hz.Flush_E   = ~RST & ~mem_wait & (hz.PC_Src_E | load_use);
  assign hz.Freeze_EM = ~RST & mem_wait;
  assign hz.Mem_Timeout  = timeout_q;
  assign hz.Stall_Cycles = stall_cnt_q;
  assign hz.Flush_Count  = flush_cnt_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (state_q == S_RUN) begin
        if (mem_wait) begin
          state_q    <= S_WAIT;
          wait_cnt_q <= 8'd1;
        end
      end else if (!mem_wait) begin
        state_q    <= S_RUN;
        wait_cnt_q <= '0;
      end else begin
        if (wait_cnt_q != 8'hFF) wait_cnt_q <= wait_cnt_q + 8'd1;
        if (wait_cnt_q >= TMO) timeout_q <= 1'b1;
      end
      if (stall_en && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_d && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end
endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the number of consecutive data-memory wait cycles after which Mem_Timeout sets; legal range 1..255.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port Rs1_D, input, 5 bits: source register 1 of the instruction in Decode.
REQ-005 SHALL have port Rs2_D, input, 5 bits: source register 2 of the instruction in Decode.
REQ-006 SHALL have port Rd_E, input, 5 bits: destination register of the instruction in Execute.
REQ-007 SHALL have port Mem_Read_E, input, 1 bit: the instruction in Execute is a load.
REQ-008 SHALL have port PC_Src_E, input, 1 bit: a branch or jump in Execute is taken.
REQ-009 SHALL have port Dmem_Req_M, input, 1 bit: data-memory access active in Memory stage.
REQ-010 SHALL have port Dmem_Ready_M, input, 1 bit: data memory completes the access this cycle.
REQ-011 SHALL have port Stall_F, output, 1 bit: hold the PC.
REQ-012 SHALL have port Stall_En, output, 1 bit: hold the Fetch-to-Decode register.
REQ-013 SHALL have port Flush_D, output, 1 bit: insert a NOP into the Fetch-to-Decode register.
REQ-014 SHALL have port Flush_E, output, 1 bit: insert a bubble into the Decode-to-Execute register.
REQ-015 SHALL have port Freeze_EM, output, 1 bit: hold the Decode-to-Execute, Execute-to-Memory and Memory-to-Writeback registers.
REQ-016 SHALL have port Mem_Timeout, output, 1 bit: sticky flag for a memory wait reaching TIMEOUT_CYCLES.
REQ-017 SHALL have port Stall_Cycles, output, 16 bits: saturating count of cycles with Stall_En=1.
REQ-018 SHALL have port Flush_Count, output, 16 bits: saturating count of cycles with Flush_D=1.

Function
REQ-019 SHALL drive Stall_F, Stall_En, Flush_D, Flush_E and Freeze_EM combinationally from the current inputs and RST, with zero-cycle latency.
REQ-020 SHALL define mem_wait = Dmem_Req_M & ~Dmem_Ready_M.
REQ-021 SHALL define load_use = Mem_Read_E & (Rd_E != 0) & (Rd_E == Rs1_D | Rd_E == Rs2_D).
REQ-022 SHALL resolve simultaneous conditions in priority order: RST, then mem_wait, then PC_Src_E, then load_use.
REQ-023 SHALL, when mem_wait, drive Stall_F=Stall_En=Freeze_EM=1 and Flush_D=Flush_E=0, so a taken branch is deferred while its stage is frozen.
REQ-024 SHALL, when PC_Src_E and not mem_wait, drive Flush_D=Flush_E=1 and Stall_F=Stall_En=Freeze_EM=0, so flush overrides a coincident load_use.
REQ-025 SHALL, when load_use only, drive Stall_F=Stall_En=Flush_E=1 and Flush_D=Freeze_EM=0.
REQ-026 SHALL otherwise drive all five control outputs 0.
REQ-027 SHALL implement a 2-state FSM, RUN and WAIT, plus an 8-bit Wait_Cnt.
REQ-028 SHALL, in RUN, go to WAIT with Wait_Cnt=1 when mem_wait, and otherwise stay in RUN.
REQ-029 SHALL, in WAIT, return to RUN and clear Wait_Cnt when ~mem_wait, and otherwise increment Wait_Cnt, saturating at 255.
REQ-030 SHALL set Mem_Timeout on the clock edge where the state is WAIT, mem_wait=1 and Wait_Cnt >= TIMEOUT_CYCLES; once set it clears only on RST and does not alter the stall outputs.
REQ-031 SHALL increment Stall_Cycles on each edge where Stall_En=1, holding at 16'hFFFF with no wrap.
REQ-032 SHALL increment Flush_Count on each edge where Flush_D=1, holding at 16'hFFFF with no wrap.
REQ-033 SHALL treat a mem_wait lasting exactly one cycle (Ready on the next cycle) as a single RUN->WAIT->RUN round trip with one stall cycle counted.

Reset
REQ-034 SHALL, while RST=1, force Stall_F=Stall_En=Flush_D=Flush_E=Freeze_EM=0 regardless of the other inputs.
REQ-035 SHALL, on an edge with RST=1, set state=RUN, Wait_Cnt=0, Mem_Timeout=0, Stall_Cycles=0 and Flush_Count=0, including when asserted mid-WAIT.

Verification
REQ-036 Bench SHALL cover: load-use, Mem_Read_E=1, Rd_E=5, Rs1_D=5 -> Stall_F=Stall_En=Flush_E=1, Flush_D=0; after one edge Stall_Cycles=1.
REQ-037 Bench SHALL cover: Rd_E=0 with Rs1_D=0 and Mem_Read_E=1 -> all control outputs 0, counters unchanged.
REQ-038 Bench SHALL cover: PC_Src_E=1 together with load_use -> Flush_D=Flush_E=1, Stall_En=0; Flush_Count increments by 1.
REQ-039 Bench SHALL cover: Dmem_Req_M=1 with Ready=0 for 3 cycles then Ready=1, and PC_Src_E=1 throughout -> Freeze_EM=1 and flushes 0 for 3 cycles, then Flush_D=1; Stall_Cycles=3.
REQ-040 Bench SHALL cover: TIMEOUT_CYCLES=4 with Ready=0 held for 6 cycles -> Mem_Timeout=1 after the 4th WAIT edge, staying 1 after Ready; RST one cycle -> Mem_Timeout=0.
REQ-041 Bench SHALL cover: RST asserted mid-WAIT with Stall_Cycles=10 -> outputs 0 during RST; next cycle state RUN and both counters 0.
